lane_collector: RTL and testbench
=================================

Name: lane_collector

Overview:
- Receive-side counterpart of the 4-lane recirculation path. Takes the four 8-bit data+valid lanes coming back from the lane/mux datapath.
- Compacts the valid lanes, in lane order, into a byte FIFO and drains them as a single byte stream under a valid/ready handshake.
- Runs an idle-detection FSM whose output drives the recirculator's IDLE selector.

Parameters:
- DATA_WIDTH, 8, width of each lane and of the output byte.
- DEPTH, 16, FIFO entries; power of 2, minimum 8.
- IDLE_CYCLES, 4, consecutive quiet cycles required before idle_out asserts; minimum 1.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in0..data_in3  input  DATA_WIDTH each  lane data.
- valid_in0..valid_in3  input  1 each  lane valid.
- in_ready  output  1  collector can accept a full 4-lane beat this cycle.
- data_out  output  DATA_WIDTH  FIFO head byte.
- valid_out  output  1  data_out holds a valid byte.
- ready_out  input  1  downstream accepts data_out.
- fifo_count  output  log2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky: a valid lane arrived while in_ready=0.
- idle_out  output  1  lanes quiet and FIFO drained; drives selector_IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - FIFO empty; pointers 0; fifo_count=0.
  - valid_out=0; overflow_err=0; idle_out=0.
  - FSM=ACTIVE; idle counter=0.
  - data_out is don't-care while valid_out=0.
  - Reset asserted mid-operation discards all FIFO contents the next cycle. Inputs presented during reset are ignored.
- in_ready: combinational, = (DEPTH - fifo_count) >= 4. Depends on the registered count only, never on ready_out.
- Push:
  - Applies on a cycle with in_ready=1. Each lane with valid_inN=1 is written in ascending lane order into consecutive FIFO slots.
  - Invalid lanes are skipped, so the sequence is compacted: e.g. lanes 1 and 3 valid produce 2 entries, lane 1 first.
  - push_n = popcount(valid_in0..3), 0..4.
- Overflow: any valid_inN=1 while in_ready=0 drops the whole beat and sets overflow_err=1. overflow_err is cleared only by reset.
- Pop (first-word-fall-through):
  - data_out = mem[rd_ptr]; valid_out = (fifo_count != 0), registered-count based.
  - Pop occurs when valid_out and ready_out are both 1 on a clock edge.
  - data_out/valid_out are stable while ready_out=0.
- Count update: fifo_count <= fifo_count + push_n - pop.
  - Push and pop in the same cycle are both honoured.
  - Pop on empty is impossible because valid_out=0.
- Pointers: wrap modulo DEPTH. The write pointer advances by push_n.
- Latency: a byte pushed into an empty FIFO at edge N appears with valid_out=1 after edge N, i.e. one cycle later.
- Full boundary: in_ready=0 when fifo_count > DEPTH-4, even if fewer than 4 lanes are valid. No partial beats are accepted.
- Idle FSM (2 states):
  - quiet = (no valid_inN) and (fifo_count==0).
  - ACTIVE: the counter increments each quiet cycle and resets to 0 on any non-quiet cycle. On the cycle the counter reaches IDLE_CYCLES-1 while quiet, go to IDLE.
  - IDLE: idle_out=1. Any valid_inN=1 returns the FSM to ACTIVE at the next edge with the counter cleared; idle_out=0 from that edge. The beat itself is pushed normally.
  - idle_out is registered: asserts exactly IDLE_CYCLES edges after the first quiet cycle.

Test Plan:
- Reset then 10 quiet cycles:
  - valid_out=0 and in_ready=1 throughout.
  - idle_out rises after edge 4 (IDLE_CYCLES=4) and stays 1.
- One beat, lanes 0..3 = 0x11,0x22,0x33,0x44 all valid, ready_out=1:
  - data_out sequence 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting one cycle after the push.
  - fifo_count returns to 0.
- Sparse beat, valid only on lane1=0xA5 and lane3=0x5A:
  - Exactly 2 pops: 0xA5 then 0x5A.
  - fifo_count peaks at 2.
- ready_out=0, push 4 full beats:
  - fifo_count=16 and in_ready=0 (in_ready already 0 at count 13..16).
  - A 5th beat sets overflow_err=1 and leaves fifo_count=16.
  - Then ready_out=1 drains all 16 bytes in order across the pointer wrap.
- Simultaneous push and pop: FIFO at count 5, ready_out=1, push 3 valid lanes -> count 7 next cycle.
- In IDLE, assert valid_in2=0x7E:
  - idle_out=0 after the next edge; 0x7E delivered.
  - Then reset mid-drain with 6 entries -> count 0 and valid_out=0 after the reset edge.

Source files
------------

// File: rtl/lane_collector_if.sv
// Lane-collector bus: four returning data+valid lanes, the compacted byte stream
// with its valid/ready handshake, and status outputs.
interface lane_collector_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_in2;
  logic [DATA_WIDTH-1:0] data_in3;
  logic                  valid_in0;
  logic                  valid_in1;
  logic                  valid_in2;
  logic                  valid_in3;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_out;
  logic [CntW-1:0]       fifo_count;
  logic                  overflow_err;
  logic                  idle_out;

  // Master drives the lanes and consumes the byte stream.
  modport master (
    output data_in0, data_in1, data_in2, data_in3,
    output valid_in0, valid_in1, valid_in2, valid_in3,
    output ready_out,
    input  in_ready, data_out, valid_out, fifo_count, overflow_err, idle_out
  );

  modport slave (
    input  data_in0, data_in1, data_in2, data_in3,
    input  valid_in0, valid_in1, valid_in2, valid_in3,
    input  ready_out,
    output in_ready, data_out, valid_out, fifo_count, overflow_err, idle_out
  );
endinterface

// File: rtl/lane_collector.sv
// Compacts four returning lanes into a first-word-fall-through byte FIFO and
// flags idle once the lanes are quiet and the FIFO has drained.
module lane_collector #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input logic             clk,
  input logic             reset,
  lane_collector_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [0:0] {StActive, StIdle} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] laneData [4];
  logic [3:0]            laneValid;
  logic [PtrW-1:0]       laneOffs [4];
  logic [2:0]            pushN;
  logic                  anyValid, inReady, validOut, popEn, quiet;

  logic [PtrW-1:0]  wrPtrQ, wrPtrD, rdPtrQ, rdPtrD;
  logic [CntW-1:0]  countQ, countD;
  logic             overflowQ, overflowD;
  state_e           stateQ, stateD;
  logic [IdleW-1:0] idleCntQ, idleCntD;

  assign laneData[0] = bus.data_in0;
  assign laneData[1] = bus.data_in1;
  assign laneData[2] = bus.data_in2;
  assign laneData[3] = bus.data_in3;
  assign laneValid   = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};

  assign anyValid = |laneValid;
  assign inReady  = countQ <= CntW'(DEPTH - 4);
  assign validOut = countQ != '0;
  assign popEn    = validOut & bus.ready_out;
  assign quiet    = ~anyValid & (countQ == '0);

  // Each valid lane lands at wrPtr plus the number of valid lanes below it.
  always_comb begin
    pushN = '0;
    for (int i = 0; i < 4; i++) begin
      laneOffs[i] = PtrW'(pushN);
      pushN       = pushN + 3'(laneValid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && inReady) begin
      for (int i = 0; i < 4; i++) begin
        if (laneValid[i]) mem[wrPtrQ + laneOffs[i]] <= laneData[i];
      end
    end
  end

  always_comb begin
    wrPtrD    = wrPtrQ;
    countD    = countQ - CntW'(popEn);
    rdPtrD    = rdPtrQ + PtrW'(popEn);
    overflowD = overflowQ | (anyValid & ~inReady);
    if (inReady) begin
      wrPtrD = wrPtrQ + PtrW'(pushN);
      countD = countQ + CntW'(pushN) - CntW'(popEn);
    end
  end

  always_comb begin
    stateD   = stateQ;
    idleCntD = idleCntQ;
    unique case (stateQ)
      StActive: begin
        if (!quiet) begin
          idleCntD = '0;
        end else if (idleCntQ == IdleW'(IDLE_CYCLES - 1)) begin
          stateD   = StIdle;
          idleCntD = '0;
        end else begin
          idleCntD = idleCntQ + 1'b1;
        end
      end
      StIdle: begin
        if (anyValid) begin
          stateD   = StActive;
          idleCntD = '0;
        end
      end
      default: stateD = StActive;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      overflowQ <= 1'b0;
      stateQ    <= StActive;
      idleCntQ  <= '0;
    end else begin
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
      overflowQ <= overflowD;
      stateQ    <= stateD;
      idleCntQ  <= idleCntD;
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.data_out     = mem[rdPtrQ];
  assign bus.valid_out    = validOut;
  assign bus.fifo_count   = countQ;
  assign bus.overflow_err = overflowQ;
  assign bus.idle_out     = stateQ == StIdle;
endmodule

// File: tb/tb_lane_collector.sv
// Directed bench for lane_collector: expected bytes are queued as stimulus is
// issued and a negedge monitor checks every handshake against the queue.
module tb_lane_collector;
  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  logic [7:0] expQ [$];

  lane_collector_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  lane_collector #(.DATA_WIDTH(8), .DEPTH(16), .IDLE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLanes(input logic [3:0] v, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.valid_in0 = v[0];
    bus.valid_in1 = v[1];
    bus.valid_in2 = v[2];
    bus.valid_in3 = v[3];
    bus.data_in0  = d0;
    bus.data_in1  = d1;
    bus.data_in2  = d2;
    bus.data_in3  = d3;
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake seen at negedge is the pop at the next posedge.
  always @(negedge clk) begin
    if (!reset && bus.valid_out && bus.ready_out) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no byte at %0t", bus.data_out, $time);
      end else begin
        logic [7:0] e;
        e = expQ.pop_front();
        if (bus.data_out !== e) begin
          mismatched++;
          $display("FAIL pop_data: got 0x%0h, expected 0x%0h at %0t", bus.data_out, e, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.ready_out = 1'b0;
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    check("rst_count", bus.fifo_count, 0);
    check("rst_valid_out", bus.valid_out, 0);
    check("rst_overflow", bus.overflow_err, 0);
    check("rst_idle", bus.idle_out, 0);
    check("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;

    // Ten quiet cycles: idle rises after the fourth edge and holds.
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("quiet_idle_%0d", i), bus.idle_out, (i >= 4) ? 1 : 0);
      check($sformatf("quiet_valid_%0d", i), bus.valid_out, 0);
      check($sformatf("quiet_ready_%0d", i), bus.in_ready, 1);
    end

    // Full beat streamed out on four consecutive cycles.
    bus.ready_out = 1'b1;
    setLanes(4'hF, 8'h11, 8'h22, 8'h33, 8'h44);
    expQ.push_back(8'h11); expQ.push_back(8'h22);
    expQ.push_back(8'h33); expQ.push_back(8'h44);
    tick();
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("beat_latency_valid", bus.valid_out, 1);
    check("beat_count", bus.fifo_count, 4);
    check("beat_idle_exit", bus.idle_out, 0);
    for (int i = 3; i >= 0; i--) begin
      tick();
      check($sformatf("beat_drain_%0d", i), bus.fifo_count, i);
    end

    // Sparse beat: lanes 1 and 3 only.
    setLanes(4'b1010, 8'hFF, 8'hA5, 8'hEE, 8'h5A);
    expQ.push_back(8'hA5); expQ.push_back(8'h5A);
    tick();
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("sparse_peak", bus.fifo_count, 2);
    tick();
    tick();
    check("sparse_drained", bus.fifo_count, 0);

    // Fill to 16 with the consumer stalled, then overflow.
    bus.ready_out = 1'b0;
    for (int b = 0; b < 4; b++) begin
      setLanes(4'hF, 8'(8'h80 + b * 4), 8'(8'h81 + b * 4), 8'(8'h82 + b * 4),
               8'(8'h83 + b * 4));
      for (int k = 0; k < 4; k++) expQ.push_back(8'(8'h80 + b * 4 + k));
      tick();
      check($sformatf("fill_count_%0d", b), bus.fifo_count, 4 * (b + 1));
      check($sformatf("fill_ready_%0d", b), bus.in_ready, (b < 3) ? 1 : 0);
    end
    setLanes(4'hF, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    tick();
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("ovf_flag", bus.overflow_err, 1);
    check("ovf_count", bus.fifo_count, 16);
    bus.ready_out = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("wrap_count_%0d", i), bus.fifo_count, 16 - i);
      check($sformatf("wrap_ready_%0d", i), bus.in_ready, (16 - i <= 12) ? 1 : 0);
    end
    check("ovf_sticky", bus.overflow_err, 1);

    // Simultaneous push and pop at count 5.
    bus.ready_out = 1'b0;
    setLanes(4'hF, 8'h01, 8'h02, 8'h03, 8'h04);
    expQ.push_back(8'h01); expQ.push_back(8'h02);
    expQ.push_back(8'h03); expQ.push_back(8'h04);
    tick();
    setLanes(4'b0001, 8'h05, 8'h00, 8'h00, 8'h00);
    expQ.push_back(8'h05);
    tick();
    check("simul_pre", bus.fifo_count, 5);
    bus.ready_out = 1'b1;
    setLanes(4'b1101, 8'h06, 8'hCC, 8'h07, 8'h08);
    expQ.push_back(8'h06); expQ.push_back(8'h07); expQ.push_back(8'h08);
    tick();
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("simul_count", bus.fifo_count, 7);
    repeat (7) tick();
    check("simul_drained", bus.fifo_count, 0);

    // Re-enter idle, then wake with a single lane.
    repeat (4) tick();
    check("idle_again", bus.idle_out, 1);
    setLanes(4'b0100, 8'h00, 8'h00, 8'h7E, 8'h00);
    expQ.push_back(8'h7E);
    tick();
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    check("wake_idle", bus.idle_out, 0);
    check("wake_valid", bus.valid_out, 1);
    tick();
    check("wake_drained", bus.fifo_count, 0);

    // Reset with six entries queued; lanes asserted during reset are ignored.
    bus.ready_out = 1'b0;
    setLanes(4'hF, 8'h91, 8'h92, 8'h93, 8'h94);
    tick();
    setLanes(4'b0011, 8'h95, 8'h96, 8'h00, 8'h00);
    tick();
    check("prerst_count", bus.fifo_count, 6);
    reset = 1'b1;
    bus.ready_out = 1'b1;
    setLanes(4'b0001, 8'hEE, 8'h00, 8'h00, 8'h00);
    tick();
    expQ.delete();
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_valid", bus.valid_out, 0);
    check("midrst_overflow", bus.overflow_err, 0);
    reset = 1'b0;
    setLanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    check("postrst_count", bus.fifo_count, 0);
    check("postrst_valid", bus.valid_out, 0);
    repeat (2) tick();
    check("sb_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
